// File: rtl/memory_arbiter.sv
// Two-port fixed-priority arbiter for the single-port block-chain memory.
// Port 0 wins by default; a streak counter forces a port-1 slot after STARVE_LIMIT port-0 wins.
module memory_arbiter #(
  parameter int DATA_W       = 48,
  parameter int ADDR_W       = 5,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              gnt0_r, gnt0_s;
  logic              gnt1_r, gnt1_s;
  logic              done0_r, done0_s;
  logic              done1_r, done1_s;
  logic              busy_r, busy_s;
  logic              mem_we_r, mem_we_s;
  logic              we_lat_r, we_lat_s;
  logic              port1_r, port1_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_s;
  logic [3:0]        streak_r, streak_s;
  logic              pick1_s;

  // Port 1 wins when alone, or when the starvation streak has hit its limit.
  assign pick1_s = req1 & (~req0 | (streak_r == 4'(STARVE_LIMIT)));

  // Next-state and next-output computation for every register.
  always_comb begin
    state_s     = state_r;
    gnt0_s      = gnt0_r;
    gnt1_s      = gnt1_r;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    busy_s      = busy_r;
    mem_we_s    = 1'b0;
    we_lat_s    = we_lat_r;
    port1_s     = port1_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    rdata_s     = rdata_r;
    lat_cnt_s   = lat_cnt_r;
    streak_s    = streak_r;
    case (state_r)
      IDLE: begin
        if (req0 | req1) begin
          state_s     = ACCESS;
          busy_s      = 1'b1;
          lat_cnt_s   = '0;
          port1_s     = pick1_s;
          gnt0_s      = ~pick1_s;
          gnt1_s      = pick1_s;
          // mem_addr/mem_wdata double as the latched request; they hold until the next win.
          we_lat_s    = pick1_s ? we1 : we0;
          mem_we_s    = pick1_s ? we1 : we0;
          mem_addr_s  = pick1_s ? addr1 : addr0;
          mem_wdata_s = pick1_s ? wdata1 : wdata0;
          if (pick1_s) begin
            streak_s = 4'd0;
          end else if (req1) begin
            streak_s = (streak_r == 4'd15) ? streak_r : streak_r + 4'd1;
          end else begin
            streak_s = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_lat_r) begin
          state_s = COMPLETE;
          done0_s = ~port1_r;
          done1_s = port1_r;
        end else if (lat_cnt_r == LAT_W'(RD_LAT - 1)) begin
          state_s = COMPLETE;
          rdata_s = mem_rdata;
          done0_s = ~port1_r;
          done1_s = port1_r;
        end else begin
          lat_cnt_s = lat_cnt_r + LAT_W'(1);
        end
      end
      COMPLETE: begin
        state_s = IDLE;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= IDLE;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      we_lat_r    <= 1'b0;
      port1_r     <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rdata_r     <= '0;
      lat_cnt_r   <= '0;
      streak_r    <= 4'd0;
    end else begin
      state_r     <= state_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      done0_r     <= done0_s;
      done1_r     <= done1_s;
      busy_r      <= busy_s;
      mem_we_r    <= mem_we_s;
      we_lat_r    <= we_lat_s;
      port1_r     <= port1_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      rdata_r     <= rdata_s;
      lat_cnt_r   <= lat_cnt_s;
      streak_r    <= streak_s;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign done0     = done0_r;
  assign done1     = done1_r;
  assign busy      = busy_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected completions are queued at issue
// and popped when done0/done1 pulse; cycle-exact checks cover latency and reset.
module tb_memory_arbiter;
  localparam int DATA_W       = 48;
  localparam int ADDR_W       = 5;
  localparam int RD_LAT       = 2;
  localparam int STARVE_LIMIT = 3;

  logic              clock = 1'b0;
  logic              resetn;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, done0, gnt1, done1, mem_we, busy;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  typedef struct {
    logic              port;
    logic              is_read;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] ref_mem [0:31];
  logic [DATA_W-1:0] tb_mem  [0:31];
  logic [DATA_W-1:0] rd_pipe;
  int                checks_cnt = 0;
  int                fail_cnt   = 0;

  always #5 clock = ~clock;

  memory_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM model: write on mem_we, read data appears RD_LAT-1 edges after the address.
  always @(posedge clock) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    rd_pipe <= tb_mem[mem_addr];
  end
  assign mem_rdata = rd_pipe;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic port, input logic is_read,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    exp_t e;
    e.port    = port;
    e.is_read = is_read;
    if (!is_read) ref_mem[addr] = wd;
    e.data = ref_mem[addr];
    exp_q.push_back(e);
  endtask

  // Completion monitor: pop the scoreboard on every done pulse, plus exclusivity checks.
  always @(negedge clock) begin
    check_eq("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    check_eq("done_excl", 64'(done0 & done1), 64'd0);
    if (done0 || done1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_port", 64'(done1), 64'(mon_e.port));
        if (mon_e.is_read) check_eq("sb_rdata", 64'(rdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    logic [7:0] order_v;
    int         n;
    bit         seen;

    resetn = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;

    // Reset with both requests high
    repeat (3) @(negedge clock);
    check_eq("rst_gnt0", 64'(gnt0), 64'd0);
    check_eq("rst_gnt1", 64'(gnt1), 64'd0);
    check_eq("rst_done0", 64'(done0), 64'd0);
    check_eq("rst_done1", 64'(done1), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    resetn = 1'b1;
    @(negedge clock);

    // Port-0 write
    we0 = 1'b1; addr0 = 5'd5; wdata0 = 48'h123456789ABC;
    push_exp(1'b0, 1'b0, 5'd5, 48'h123456789ABC);
    req0 = 1'b1;
    @(negedge clock);
    check_eq("w0_c1_gnt0", 64'(gnt0), 64'd1);
    check_eq("w0_c1_gnt1", 64'(gnt1), 64'd0);
    check_eq("w0_c1_mem_we", 64'(mem_we), 64'd1);
    check_eq("w0_c1_mem_addr", 64'(mem_addr), 64'd5);
    check_eq("w0_c1_mem_wdata", 64'(mem_wdata), 64'h123456789ABC);
    check_eq("w0_c1_done0", 64'(done0), 64'd0);
    check_eq("w0_c1_busy", 64'(busy), 64'd1);
    @(negedge clock);
    check_eq("w0_c2_done0", 64'(done0), 64'd1);
    check_eq("w0_c2_mem_we", 64'(mem_we), 64'd0);
    check_eq("w0_c2_gnt0", 64'(gnt0), 64'd1);
    req0 = 1'b0;
    @(negedge clock);
    check_eq("w0_c3_busy", 64'(busy), 64'd0);
    check_eq("w0_c3_gnt0", 64'(gnt0), 64'd0);
    check_eq("w0_c3_done0", 64'(done0), 64'd0);

    // Port-1 read of the same address
    we1 = 1'b0; addr1 = 5'd5;
    push_exp(1'b1, 1'b1, 5'd5, '0);
    req1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      check_eq("r1_mem_we", 64'(mem_we), 64'd0);
      check_eq("r1_gnt1", 64'(gnt1), 64'd1);
      check_eq("r1_done1", 64'(done1), (c == 3) ? 64'd1 : 64'd0);
      if (c == 3) begin
        check_eq("r1_rdata", 64'(rdata), 64'h123456789ABC);
        req1 = 1'b0;
      end
    end
    @(negedge clock);
    check_eq("r1_idle_busy", 64'(busy), 64'd0);
    check_eq("r1_idle_gnt1", 64'(gnt1), 64'd0);

    // Simultaneous requests: port-0 write then port-1 read of the new data
    we0 = 1'b1; addr0 = 5'd1; wdata0 = 48'hCAFE0000BEEF;
    we1 = 1'b0; addr1 = 5'd1;
    push_exp(1'b0, 1'b0, 5'd1, 48'hCAFE0000BEEF);
    push_exp(1'b1, 1'b1, 5'd1, '0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clock);
    check_eq("sim_c1_gnt0", 64'(gnt0), 64'd1);
    check_eq("sim_c1_gnt1", 64'(gnt1), 64'd0);
    @(negedge clock);
    check_eq("sim_c2_done0", 64'(done0), 64'd1);
    req0 = 1'b0;
    @(negedge clock);
    check_eq("sim_c3_busy", 64'(busy), 64'd0);
    @(negedge clock);
    check_eq("sim_c4_gnt1", 64'(gnt1), 64'd1);
    @(negedge clock);
    @(negedge clock);
    check_eq("sim_c6_done1", 64'(done1), 64'd1);
    check_eq("sim_c6_rdata", 64'(rdata), 64'hCAFE0000BEEF);
    req1 = 1'b0;
    @(negedge clock);

    // Starvation guard: both ports keep requesting, expect 0,0,0,1,0,0,0,1
    order_v = 8'b1000_1000;
    we0 = 1'b1; addr0 = 5'd7; wdata0 = 48'hA0A0A0A0A0A0;
    we1 = 1'b1; addr1 = 5'd8; wdata1 = 48'hB1B1B1B1B1B1;
    for (int i = 0; i < 8; i++) begin
      if (order_v[i]) push_exp(1'b1, 1'b0, 5'd8, 48'hB1B1B1B1B1B1);
      else            push_exp(1'b0, 1'b0, 5'd7, 48'hA0A0A0A0A0A0);
    end
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
      @(negedge clock);
      if (done0 || done1) begin
        check_eq($sformatf("starve_order%0d", n), 64'(done1), 64'(order_v[n]));
        n++;
        if (n == 8) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq("starve_count", 64'(n), 64'd8);
    @(negedge clock);
    @(negedge clock);
    check_eq("starve_idle_busy", 64'(busy), 64'd0);

    // Reset during the second ACCESS cycle of a port-1 read
    we1 = 1'b0; addr1 = 5'd5;
    req1 = 1'b1;
    @(negedge clock);
    check_eq("mr_c1_gnt1", 64'(gnt1), 64'd1);
    @(negedge clock);
    resetn = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_gnt1", 64'(gnt1), 64'd0);
    check_eq("mr_done1", 64'(done1), 64'd0);
    check_eq("mr_rdata", 64'(rdata), 64'd0);
    check_eq("mr_mem_we", 64'(mem_we), 64'd0);
    resetn = 1'b1;
    @(negedge clock);
    check_eq("mr_post_done1", 64'(done1), 64'd0);

    // Fresh port-1 read after reset release
    addr1 = 5'd1;
    push_exp(1'b1, 1'b1, 5'd1, '0);
    req1 = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clock);
      if (done1) begin
        seen = 1'b1;
        check_eq("fresh_rdata", 64'(rdata), 64'hCAFE0000BEEF);
        req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    check_eq("fresh_done_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clock);

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port block-chain memory between two requesters: port 0 is the mining/memory controller, port 1 is the display/readback unit.
- Accepts one single-word transaction at a time through a req/gnt/done handshake.
- Drives the RAM address, write-data and write-enable pins, and waits out the RAM read latency before returning data.
- Port 0 has fixed priority. A starvation guard guarantees port 1 gets a slot after STARVE_LIMIT consecutive port-0 wins.

Parameters:
DATA_W, 48, memory word width
ADDR_W, 5, memory address width
RD_LAT, 2, RAM read latency in cycles (>=1)
STARVE_LIMIT, 3, consecutive port-0 grants allowed while port 1 waits (1..15)

Ports:
clock  input  1  system clock
resetn  input  1  reset
req0  input  1  port-0 request, held until done0
we0  input  1  port-0 write (1) / read (0)
addr0  input  ADDR_W  port-0 address
wdata0  input  DATA_W  port-0 write data
gnt0  output  1  port 0 owns the memory
done0  output  1  one-cycle port-0 completion pulse
req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  port-1 equivalents
gnt1, done1  output  1/1  port-1 equivalents
rdata  output  DATA_W  last read data; valid with done of a read
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_we  output  1  RAM write enable
mem_rdata  input  DATA_W  RAM read data
busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Reset is on clock, resetn, synchronous, active-low.
- Reset forces IDLE and zeroes every output, the latched request registers, the latency counter and the streak counter. This holds on any cycle, including mid-transaction: mem_we is low from the next edge and no done pulse is issued for the aborted access.
- States: IDLE, ACCESS, COMPLETE.
- IDLE, arbitration:
  - Requests are sampled only in IDLE.
  - Winner is port 0 if req0 is high, except port 1 wins when req1 is high and streak == STARVE_LIMIT.
  - If only one request is high, that port wins.
  - On a win: latch we/addr/wdata of the winner, set gnt of the winner, clear the latency counter, go to ACCESS.
  - With no request, stay in IDLE.
- Streak counter:
  - +1 on a port-0 grant while req1 is high (saturating at 15).
  - Cleared on any port-1 grant, or on a port-0 grant while req1 is low.
- ACCESS:
  - mem_addr and mem_wdata = latched values.
  - Write: mem_we = 1 for exactly this single cycle, then go to COMPLETE.
  - Read: mem_we = 0. Stay RD_LAT cycles; on the last cycle, rdata <= mem_rdata; go to COMPLETE.
- COMPLETE: done of the granted port = 1 for one cycle; gnt drops at the end of this cycle; go to IDLE.
- Latency, counting the IDLE sampling cycle as cycle 0:
  - gnt rises at cycle 1.
  - Write: done at cycle 2.
  - Read: done at cycle RD_LAT+1.
- Back-to-back transactions: minimum 1 IDLE cycle between them.
- Requester rule: a port deasserts req on the edge at which it samples done. A req still high in the following IDLE cycle is a new transaction.
- Requester inputs must be stable from req rise until done. Changes after the latch edge are ignored.
- rdata holds its value until the next read capture; writes do not alter it.
- mem_addr/mem_wdata hold their last values in IDLE/COMPLETE; mem_we is 0 outside ACCESS.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles with req0=req1=1 -> gnt0/1, done0/1, mem_we, busy, rdata all 0.
- Port-0 write: req0=1, we0=1, addr0=5, wdata0=48'h123456789ABC -> gnt0 at cycle 1; mem_we=1 with mem_addr=5 for exactly cycle 1; done0 at cycle 2; IDLE at cycle 3.
- Port-1 read after that write, RD_LAT=2: req1=1, we1=0, addr1=5 -> gnt1 cycles 1-3; done1 at cycle 3 with rdata=48'h123456789ABC; mem_we never asserted.
- Simultaneous requests: req0 (write addr 1) and req1 (read addr 1) rise together -> port 0 served first (done0 at cycle 2), then port 1 granted in the next arbitration and returns the new data.
- Starvation guard, STARVE_LIMIT=3: req0 re-requests immediately after each done while req1 is held high -> grant order 0,0,0,1,0; streak returns to 0 after the port-1 grant.
- Mid-operation reset: resetn=0 during the second ACCESS cycle of a port-1 read -> next edge IDLE, gnt1=0, done1 never pulses, rdata=0; after release, a fresh req1 completes normally.
